mdio_cmd_sequencer: RTL and testbench

Host-side command front end for the MDIO management master. Accepts register read/write requests through a valid/ready handshake and assembles the 32-bit management frame (ST, OP, PHYAD, REGAD, TA, DATA). It drives the master's `T_DATA`/`MDIO_START`, waits for completion (a fixed write duration, or `DATA_RDY` for reads, with a timeout), and returns read data or an error through a response handshake. One transaction is outstanding at a time.

---
 rtl/mdio_pkg.sv | 48 ++++
 rtl/mdio_cmd_sequencer_if.sv | 38 +++
 rtl/mdio_wait_timer.sv | 36 +++
 rtl/mdio_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_mdio_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdio_pkg
// Description : Shared MDIO frame codes, field positions, FSM states and the
//               frame packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mdio_pkg;

    localparam logic [1:0] c_ST_CODE = 2'b01;
    localparam logic [1:0] c_OP_WR   = 2'b01;
    localparam logic [1:0] c_OP_RD   = 2'b10;
    localparam logic [1:0] c_TA_WR   = 2'b10;
    localparam logic [1:0] c_TA_RD   = 2'b11;

    localparam int FRM_ST_LSB  = 30;
    localparam int FRM_OP_LSB  = 28;
    localparam int FRM_PHY_LSB = 23;
    localparam int FRM_REG_LSB = 18;
    localparam int FRM_TA_LSB  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT_WR = 3'd2,
        S_WAIT_RD = 3'd3,
        S_RESP    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    // Read frames carry zeros in the data field; the PHY drives it.
    function automatic logic [31:0] pack_frame(input logic        wr,
                                               input logic [4:0]  phyad,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
        logic [31:0] f;
        f = '0;
        f[FRM_ST_LSB  +: 2] = c_ST_CODE;
        f[FRM_OP_LSB  +: 2] = wr ? c_OP_WR : c_OP_RD;
        f[FRM_PHY_LSB +: 5] = phyad;
        f[FRM_REG_LSB +: 5] = regad;
        f[FRM_TA_LSB  +: 2] = wr ? c_TA_WR : c_TA_RD;
        f[15:0]             = wr ? wdata : 16'h0000;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mdio_cmd_sequencer_if
// Description : Request/response handshake and MDIO master link bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdio_cmd_sequencer_if;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WR;
    logic [4:0]  REQ_PHYAD;
    logic [4:0]  REQ_REGAD;
    logic [15:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] T_DATA;
    logic        MDIO_START;
    logic        DATA_RDY;
    logic [15:0] RD_DATA;

    // master: host plus MDIO engine side; slave: the sequencer itself
    modport master (
        output REQ_VALID, REQ_WR, REQ_PHYAD, REQ_REGAD, REQ_WDATA,
        output RSP_READY, DATA_RDY, RD_DATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, T_DATA, MDIO_START
    );

    modport slave (
        input  REQ_VALID, REQ_WR, REQ_PHYAD, REQ_REGAD, REQ_WDATA,
        input  RSP_READY, DATA_RDY, RD_DATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, T_DATA, MDIO_START
    );

endinterface
`default_nettype wire

// File: rtl/mdio_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mdio_wait_timer
// Description : Loadable saturating up-counter with clear, enable and
//               terminal-count compare.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_wait_timer #(
    parameter int WIDTH = 8
) (
    input  wire             clk,
    input  wire             RESET,
    input  wire             i_clr,
    input  wire             i_en,
    input  wire             i_load,
    input  wire [WIDTH-1:0] i_load_val,
    input  wire [WIDTH-1:0] i_term_val,
    output logic            o_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (RESET || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_term = (r_count == i_term_val);

endmodule
`default_nettype wire

// File: rtl/mdio_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdio_cmd_sequencer
// Description : Host command front end: builds MDIO frames, launches the
//               master, waits for completion and returns a response.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_cmd_sequencer
    import mdio_pkg::*;
#(
    parameter int WR_CYCLES  = 64,
    parameter int RD_TIMEOUT = 255,
    parameter int IDLE_GAP   = 2
) (
    input  wire                  clk,
    input  wire                  RESET,
    mdio_cmd_sequencer_if.slave  bus
);

    localparam int c_MAX_WR_RD = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
    localparam int c_MAX_ALL   = (c_MAX_WR_RD > IDLE_GAP) ? c_MAX_WR_RD : IDLE_GAP;
    localparam int TW          = $clog2(c_MAX_ALL + 1);

    localparam logic [TW-1:0] c_WR_TERM  = TW'(WR_CYCLES - 1);
    localparam logic [TW-1:0] c_RD_TERM  = TW'(RD_TIMEOUT - 1);
    localparam logic [TW-1:0] c_GAP_TERM = TW'(IDLE_GAP - 1);

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_frame;
    logic [15:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic          r_rdy_prev;
    logic          w_accept;
    logic          w_rdy_edge;
    logic          w_tmr_en;
    logic          w_tmr_term;
    logic [TW-1:0] w_tmr_term_val;

    assign w_accept   = bus.REQ_VALID && bus.REQ_READY;
    assign w_rdy_edge = bus.DATA_RDY && !r_rdy_prev;
    assign w_tmr_en   = (r_state == S_WAIT_WR) || (r_state == S_WAIT_RD) || (r_state == S_GAP);

    // Terminal value is a pure function of state so it never loops through the FSM.
    assign w_tmr_term_val = (r_state == S_WAIT_WR) ? c_WR_TERM :
                            (r_state == S_WAIT_RD) ? c_RD_TERM : c_GAP_TERM;

    mdio_wait_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .RESET      (RESET),
        .i_clr      (!w_tmr_en),
        .i_en       (w_tmr_en),
        .i_load     (1'b0),
        .i_load_val ({TW{1'b0}}),
        .i_term_val (w_tmr_term_val),
        .o_term     (w_tmr_term)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = (r_frame[FRM_OP_LSB +: 2] == c_OP_WR) ? S_WAIT_WR : S_WAIT_RD;
            S_WAIT_WR: if (w_tmr_term) w_next = S_RESP;
            S_WAIT_RD: if (w_rdy_edge || w_tmr_term) w_next = S_RESP;
            S_RESP:    if (bus.RSP_READY) w_next = S_GAP;
            S_GAP:     if (w_tmr_term) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_frame     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rdy_prev  <= 1'b0;
        end else begin
            r_rdy_prev <= bus.DATA_RDY;
            if (w_accept) begin
                r_frame <= pack_frame(bus.REQ_WR, bus.REQ_PHYAD, bus.REQ_REGAD, bus.REQ_WDATA);
            end
            if ((r_state == S_WAIT_WR) && w_tmr_term) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end else if (r_state == S_WAIT_RD) begin
                // A data edge coinciding with the timeout still counts as success.
                if (w_rdy_edge) begin
                    r_rsp_rdata <= bus.RD_DATA;
                    r_rsp_err   <= 1'b0;
                end else if (w_tmr_term) begin
                    r_rsp_rdata <= 16'hFFFF;
                    r_rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign bus.REQ_READY  = (r_state == S_IDLE) && !RESET;
    assign bus.MDIO_START = (r_state == S_LAUNCH);
    assign bus.RSP_VALID  = (r_state == S_RESP);
    assign bus.RSP_RDATA  = r_rsp_rdata;
    assign bus.RSP_ERR    = r_rsp_err;
    assign bus.T_DATA     = (r_state == S_IDLE) ? 32'h0 : r_frame;

endmodule
`default_nettype wire

// File: tb/tb_mdio_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mdio_cmd_sequencer
// Description : Self-checking bench for mdio_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_cmd_sequencer;

    localparam int WR_CYCLES  = 64;
    localparam int RD_TIMEOUT = 255;
    localparam int IDLE_GAP   = 2;
    localparam int BOUND      = 1000;

    logic clk = 1'b0;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;

    mdio_cmd_sequencer_if bus();

    mdio_cmd_sequencer #(
        .WR_CYCLES  (WR_CYCLES),
        .RD_TIMEOUT (RD_TIMEOUT),
        .IDLE_GAP   (IDLE_GAP)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame value built from the field definitions with plain arithmetic.
    function automatic logic [31:0] model_frame(input bit wr, input logic [4:0] phy,
                                                input logic [4:0] rg, input logic [15:0] wd);
        int unsigned f;
        f = 32'h4000_0000;
        f += (wr ? 32'd1 : 32'd2) * 32'h1000_0000;
        f += 32'(phy) * 32'h0080_0000;
        f += 32'(rg)  * 32'h0004_0000;
        f += (wr ? 32'd2 : 32'd3) * 32'h0001_0000;
        if (wr) f += 32'(wd);
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns in the cycle after the accept edge.
    task automatic issue(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input bit keep);
        int n;
        bus.REQ_WR    = wr;
        bus.REQ_PHYAD = phy;
        bus.REQ_REGAD = rg;
        bus.REQ_WDATA = wd;
        bus.REQ_VALID = 1'b1;
        n = 0;
        while (!bus.REQ_READY && n < BOUND) begin
            tick();
            n++;
        end
        tick();
        if (!keep) bus.REQ_VALID = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.RSP_VALID && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_and_gap(output int n);
        bus.RSP_READY = 1'b1;
        tick();
        bus.RSP_READY = 1'b0;
        n = 1;
        while (!bus.REQ_READY && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) tick();
        checks++; if (bus.REQ_READY !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", bus.REQ_READY); end
        checks++; if (bus.RSP_VALID !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.RSP_VALID); end
        checks++; if (bus.RSP_RDATA !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", bus.RSP_RDATA); end
        checks++; if (bus.RSP_ERR !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.RSP_ERR); end
        checks++; if (bus.T_DATA !== 32'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=00000000", bus.T_DATA); end
        checks++; if (bus.MDIO_START !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", bus.MDIO_START); end
        RESET = 1'b0;
        #1;
        checks++; if (bus.REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.REQ_READY); end
        tick();
    endtask

    task automatic test_write(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        logic [31:0] exp;
        int n, g;
        exp = model_frame(1'b1, phy, rg, wd);
        issue(1'b1, phy, rg, wd, 1'b0);
        checks++; if (bus.MDIO_START !== 1'b1) begin failures++; $display("FAIL wr_start got=%b exp=1", bus.MDIO_START); end
        checks++; if (bus.T_DATA !== exp) begin failures++; $display("FAIL wr_frame got=%h exp=%h", bus.T_DATA, exp); end
        tick();
        checks++; if (bus.MDIO_START !== 1'b0) begin failures++; $display("FAIL wr_start_pulse got=%b exp=0", bus.MDIO_START); end
        wait_rsp(n);
        checks++; if (n + 1 !== WR_CYCLES + 1) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", n + 1, WR_CYCLES + 1); end
        checks++; if (bus.RSP_RDATA !== 16'h0 || bus.RSP_ERR !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%h/%b exp=0000/0", bus.RSP_RDATA, bus.RSP_ERR); end
        checks++; if (bus.T_DATA !== exp) begin failures++; $display("FAIL wr_frame_hold got=%h exp=%h", bus.T_DATA, exp); end
        ack_and_gap(g);
        checks++; if (g !== IDLE_GAP + 1) begin failures++; $display("FAIL wr_gap got=%0d exp=%0d", g, IDLE_GAP + 1); end
        checks++; if (bus.T_DATA !== 32'h0) begin failures++; $display("FAIL wr_idle_tdata got=%h exp=00000000", bus.T_DATA); end
    endtask

    task automatic test_read(input logic [4:0] phy, input logic [4:0] rg, input int d, input logic [15:0] rdata);
        logic [31:0] exp;
        int g;
        exp = model_frame(1'b0, phy, rg, 16'h0);
        bus.DATA_RDY = 1'b0;
        issue(1'b0, phy, rg, 16'($urandom), 1'b0);
        checks++; if (bus.MDIO_START !== 1'b1) begin failures++; $display("FAIL rd_start got=%b exp=1", bus.MDIO_START); end
        checks++; if (bus.T_DATA !== exp) begin failures++; $display("FAIL rd_frame got=%h exp=%h", bus.T_DATA, exp); end
        repeat (d) tick();
        checks++; if (bus.RSP_VALID !== 1'b0) begin failures++; $display("FAIL rd_early got=%b exp=0", bus.RSP_VALID); end
        bus.DATA_RDY = 1'b1;
        bus.RD_DATA  = rdata;
        tick();
        checks++; if (bus.RSP_VALID !== 1'b1) begin failures++; $display("FAIL rd_latency d=%0d got=%b exp=1", d, bus.RSP_VALID); end
        checks++; if (bus.RSP_RDATA !== rdata || bus.RSP_ERR !== 1'b0) begin failures++; $display("FAIL rd_rsp got=%h/%b exp=%h/0", bus.RSP_RDATA, bus.RSP_ERR, rdata); end
        bus.RD_DATA  = ~rdata;
        bus.DATA_RDY = 1'b0;
        tick();
        checks++; if (bus.RSP_RDATA !== rdata) begin failures++; $display("FAIL rd_hold got=%h exp=%h", bus.RSP_RDATA, rdata); end
        ack_and_gap(g);
        checks++; if (g !== IDLE_GAP + 1) begin failures++; $display("FAIL rd_gap got=%0d exp=%0d", g, IDLE_GAP + 1); end
    endtask

    task automatic test_timeout(input bit stuck);
        int n, g;
        bus.DATA_RDY = stuck;
        bus.RD_DATA  = 16'($urandom);
        issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b0);
        checks++; if (bus.MDIO_START !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", bus.MDIO_START); end
        tick();
        wait_rsp(n);
        checks++; if (n + 1 !== RD_TIMEOUT + 1) begin failures++; $display("FAIL to_latency stuck=%0d got=%0d exp=%0d", stuck, n + 1, RD_TIMEOUT + 1); end
        checks++; if (bus.RSP_ERR !== 1'b1 || bus.RSP_RDATA !== 16'hFFFF) begin failures++; $display("FAIL to_rsp got=%h/%b exp=ffff/1", bus.RSP_RDATA, bus.RSP_ERR); end
        bus.DATA_RDY = 1'b0;
        ack_and_gap(g);
        checks++; if (g !== IDLE_GAP + 1) begin failures++; $display("FAIL to_gap got=%0d exp=%0d", g, IDLE_GAP + 1); end
    endtask

    task automatic test_backpressure;
        logic [15:0] rdata;
        int d, g;
        rdata = 16'($urandom);
        d = $urandom_range(5, 100);
        bus.DATA_RDY = 1'b0;
        issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b0);
        repeat (d) tick();
        bus.DATA_RDY = 1'b1;
        bus.RD_DATA  = rdata;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.RD_DATA   = 16'($urandom);
            bus.DATA_RDY  = 1'($urandom);
            bus.REQ_VALID = 1'b1;
            checks++;
            if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== rdata || bus.RSP_ERR !== 1'b0 || bus.REQ_READY !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%b exp=1/%h/0/0", i, bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_ERR, bus.REQ_READY, rdata);
            end
            tick();
        end
        bus.REQ_VALID = 1'b0;
        bus.DATA_RDY  = 1'b0;
        ack_and_gap(g);
        checks++; if (g !== IDLE_GAP + 1) begin failures++; $display("FAIL bp_gap got=%0d exp=%0d", g, IDLE_GAP + 1); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  pa, ra, pb, rb;
        logic [15:0] wa, rdata;
        logic [31:0] ea, eb, et;
        int n, m, bad, d, g;
        pa = 5'($urandom); ra = 5'($urandom); wa = 16'($urandom);
        pb = 5'($urandom); rb = 5'($urandom); rdata = 16'($urandom);
        ea = model_frame(1'b1, pa, ra, wa);
        eb = model_frame(1'b0, pb, rb, 16'h0);
        bus.DATA_RDY = 1'b0;
        issue(1'b1, pa, ra, wa, 1'b1);
        // Second request presented right after the accept; first frame must be unaffected.
        bus.REQ_WR = 1'b0; bus.REQ_PHYAD = pb; bus.REQ_REGAD = rb; bus.REQ_WDATA = 16'($urandom);
        checks++; if (bus.MDIO_START !== 1'b1 || bus.T_DATA !== ea) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", bus.MDIO_START, bus.T_DATA, ea); end
        bus.RSP_READY = 1'b1;
        tick();
        wait_rsp(n);
        checks++; if (n + 1 !== WR_CYCLES + 1 || bus.T_DATA !== ea) begin failures++; $display("FAIL b2b_first_rsp got=%0d/%h exp=%0d/%h", n + 1, bus.T_DATA, WR_CYCLES + 1, ea); end
        tick();
        m = 1;
        bad = 0;
        while (!bus.MDIO_START && m < BOUND) begin
            et = (m <= IDLE_GAP) ? ea : 32'h0;
            if (bus.T_DATA !== et) bad++;
            tick();
            m++;
        end
        bus.REQ_VALID = 1'b0;
        bus.RSP_READY = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", bad); end
        checks++; if (m !== IDLE_GAP + 2) begin failures++; $display("FAIL b2b_second_launch got=%0d exp=%0d", m, IDLE_GAP + 2); end
        checks++; if (bus.T_DATA !== eb) begin failures++; $display("FAIL b2b_second_frame got=%h exp=%h", bus.T_DATA, eb); end
        d = $urandom_range(1, 50);
        repeat (d) tick();
        bus.DATA_RDY = 1'b1;
        bus.RD_DATA  = rdata;
        tick();
        checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== rdata || bus.RSP_ERR !== 1'b0) begin failures++; $display("FAIL b2b_second_rsp got=%b/%h/%b exp=1/%h/0", bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_ERR, rdata); end
        bus.DATA_RDY = 1'b0;
        ack_and_gap(g);
    endtask

    task automatic test_reset_mid;
        int bad;
        bus.DATA_RDY = 1'b0;
        issue(1'b0, 5'($urandom), 5'($urandom), 16'h0, 1'b0);
        repeat (20) tick();
        RESET = 1'b1;
        tick();
        checks++; if (bus.T_DATA !== 32'h0 || bus.RSP_VALID !== 1'b0 || bus.MDIO_START !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs got=%h/%b/%b exp=0/0/0", bus.T_DATA, bus.RSP_VALID, bus.MDIO_START); end
        checks++; if (bus.REQ_READY !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", bus.REQ_READY); end
        RESET = 1'b0;
        bus.DATA_RDY = 1'b1;
        bus.RD_DATA  = 16'($urandom);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.RSP_VALID !== 1'b0 || bus.T_DATA !== 32'h0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL mid_rst_no_rsp got=%0d exp=0", bad); end
        bus.DATA_RDY = 1'b0;
        tick();
        test_write(5'($urandom), 5'($urandom), 16'($urandom));
    endtask

    initial begin
        RESET         = 1'b1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = 1'b0;
        bus.REQ_PHYAD = '0;
        bus.REQ_REGAD = '0;
        bus.REQ_WDATA = '0;
        bus.RSP_READY = 1'b0;
        bus.DATA_RDY  = 1'b0;
        bus.RD_DATA   = '0;

        test_reset();
        test_write(5'd1, 5'd0, 16'h1140);
        test_read(5'd2, 5'd1, 40, 16'h796D);
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_back_to_back();
        test_read(5'($urandom), 5'($urandom), RD_TIMEOUT, 16'($urandom));
        test_read(5'($urandom), 5'($urandom), 1, 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1)
                test_write(5'($urandom), 5'($urandom), 16'($urandom));
            else
                test_read(5'($urandom), 5'($urandom), $urandom_range(1, RD_TIMEOUT), 16'($urandom));
        end
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
